config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/fpga_cfg_pkg.sv | 25 ++
 rtl/cfg_crc8.sv | 22 ++
 rtl/config_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types for the FPGA configuration loader.
// Holds the loader FSM state enum, the CRC-8 polynomial and a CRC step helper.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    CHECK,
    FINISH
  } cfg_state_e;

  localparam logic [7:0] CFG_CRC8_POLY = 8'h07;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic       b
  );
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? CFG_CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Bit-serial CRC-8 (MSB-first, init 0x00) over the shifted bitstream.
// Ports: clk, reset, clear (restart at 0), bit_en/bit_in (one bit), crc (running value).
module cfg_crc8
  import fpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= 8'h00;
    end else if (bit_en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Loads a fabric scan chain from a word-wide bitstream, 2 clk per bit, MSB-first.
// Ports: clk, reset (sync, active-high); start; cfg_data/cfg_valid/cfg_ready word
// handshake; scan_clk/scan_en/scan_in chain drive; fabric_reset, busy, done, error.
// Optional macro CFG_LOADER_CRC_EN: CRC-8 over the shifted bits, checked against
// one trailing bitstream word; a mismatch raises the sticky error flag.
module config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 17,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_clk,
  output logic              scan_en,
  output logic              scan_in,
  output logic              fabric_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  cfg_state_e state_q, state_d;

  logic [31:0]       bit_cnt_q;
  logic [31:0]       wbit_q;
  logic [WORD_W-1:0] sh_q;
  logic              fab_rst_q;
  logic              last_bit;
  logic              word_end;
  logic              fetch_crc;
  logic              load_go;
  logic              xfer;

  assign last_bit  = (bit_cnt_q + 32'd1) == 32'(CHAIN_LEN);
  assign word_end  = (wbit_q + 32'd1) == 32'(WORD_W);
  assign load_go   = (state_q == IDLE) && start;
  assign xfer      = (state_q == FETCH) && cfg_valid;

  assign fabric_reset = fab_rst_q;

`ifdef CFG_LOADER_CRC_EN
  logic       crc_phase_q;
  logic       crc_got_q;
  logic [7:0] crc_exp_q;
  logic       err_q;
  logic [7:0] crc;
  logic       crc_ok;

  cfg_crc8 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_go),
    .bit_en (state_q == SHIFT_HI),
    .bit_in (sh_q[WORD_W-1]),
    .crc    (crc)
  );

  assign crc_ok    = crc == crc_exp_q;
  assign fetch_crc = crc_phase_q;
  assign error     = err_q;

  // The check word travels through FETCH like any other word; CHECK
  // first requests it, then compares once it has arrived.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_phase_q <= 1'b0;
      crc_got_q   <= 1'b0;
      crc_exp_q   <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      if (load_go) begin
        crc_phase_q <= 1'b0;
        crc_got_q   <= 1'b0;
        err_q       <= 1'b0;
      end
      if (xfer && crc_phase_q) begin
        crc_exp_q <= 8'(cfg_data);
        crc_got_q <= 1'b1;
      end
      if (state_q == CHECK) begin
        if (!crc_got_q) begin
          crc_phase_q <= 1'b1;
        end else if (!crc_ok) begin
          err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign fetch_crc = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    scan_clk  = 1'b0;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    busy      = state_q != IDLE;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        cfg_ready = 1'b1;
        // Keep the chain enabled across mid-load stalls.
        scan_en   = !fetch_crc && (bit_cnt_q != 32'd0);
        if (cfg_valid) state_d = fetch_crc ? CHECK : SHIFT_LO;
      end
      SHIFT_LO: begin
        scan_en = 1'b1;
        scan_in = sh_q[WORD_W-1];
        state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        scan_en  = 1'b1;
        scan_clk = 1'b1;
        scan_in  = sh_q[WORD_W-1];
        if (last_bit) begin
`ifdef CFG_LOADER_CRC_EN
          state_d = CHECK;
`else
          state_d = FINISH;
`endif
        end else if (word_end) begin
          state_d = FETCH;
        end else begin
          state_d = SHIFT_LO;
        end
      end
      CHECK: begin
`ifdef CFG_LOADER_CRC_EN
        if (!crc_got_q) state_d = FETCH;
        else if (crc_ok) state_d = FINISH;
        else state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= 32'd0;
      wbit_q    <= 32'd0;
      sh_q      <= '0;
      fab_rst_q <= 1'b1;
    end else begin
      if (load_go) begin
        bit_cnt_q <= 32'd0;
        wbit_q    <= 32'd0;
        fab_rst_q <= 1'b1;
      end
      if (xfer && !fetch_crc) begin
        sh_q   <= cfg_data;
        wbit_q <= 32'd0;
      end
      if (state_q == SHIFT_HI) begin
        bit_cnt_q <= bit_cnt_q + 32'd1;
        wbit_q    <= wbit_q + 32'd1;
        sh_q      <= {sh_q[WORD_W-2:0], 1'b0};
      end
      if (state_q == FINISH) fab_rst_q <= 1'b0;
    end
  end

endmodule
